// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush, NOP bubble injection and a saturating stall counter.
module pipe_stage_skid #(
  parameter int unsigned          OPW    = 6,
  parameter int unsigned          REGW   = 5,
  parameter int unsigned          DW     = 32,
  parameter logic [OPW-1:0]       NOP_OP = 6'b110111,
  parameter int unsigned          SKID   = 1,
  parameter int unsigned          CNTW   = 16
) (
  input  logic            clk,
  input  logic            rstd,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [REGW-1:0] in_rd,
  input  logic [REGW-1:0] in_rt,
  input  logic [DW-1:0]   in_ot,
  input  logic [DW-1:0]   in_addr,
  input  logic [DW-1:0]   in_res,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_op,
  output logic [REGW-1:0] out_rd,
  output logic [REGW-1:0] out_rt,
  output logic [DW-1:0]   out_ot,
  output logic [DW-1:0]   out_addr,
  output logic [DW-1:0]   out_res,
  input  logic            clr_stats,
  output logic [CNTW-1:0] stall_cnt
);

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rt;
    logic [DW-1:0]   ot;
    logic [DW-1:0]   addr;
    logic [DW-1:0]   res;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e          state_q;
  entry_t          main_q;
  entry_t          skid_q;
  entry_t          in_entry;
  logic            ready_q;
  logic [CNTW-1:0] stall_q;
  logic [CNTW-1:0] stall_d;
  logic            in_fire;
  logic            out_fire;

  assign in_entry = '{op: in_op, rd: in_rd, rt: in_rt, ot: in_ot, addr: in_addr, res: in_res};

  assign out_valid = (state_q != ST_EMPTY);
  // With the skid buffer in_ready is a flop, breaking the combinational ready path.
  assign in_ready  = (SKID != 0) ? ready_q : (out_ready | ~out_valid);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // The main entry always drives the outputs; only the opcode is masked to a bubble.
  assign out_op    = out_valid ? main_q.op : NOP_OP;
  assign out_rd    = main_q.rd;
  assign out_rt    = main_q.rt;
  assign out_ot    = main_q.ot;
  assign out_addr  = main_q.addr;
  assign out_res   = main_q.res;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      // NOTE: the skid entry is reset too so no stale data survives a reset.
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else if (SKID != 0) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q  <= in_entry;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_q <= in_entry;
          end else if (in_fire) begin
            skid_q  <= in_entry;
            state_q <= ST_SKID;
            ready_q <= 1'b0;
          end else if (out_fire) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_q  <= skid_q;
            state_q <= ST_FULL;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end else begin
      if (in_fire) begin
        main_q  <= in_entry;
        state_q <= ST_FULL;
      end else if (out_fire) begin
        state_q <= ST_EMPTY;
      end
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != {CNTW{1'b1}})) begin
      stall_d = stall_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid (16/4-bit counter) and non-skid
// instances share one stimulus bus; each phase checks the instance it targets.
module tb_pipe_stage_skid;

  localparam logic [5:0] NOP = 6'b110111;

  logic        clk = 1'b0;
  logic        rstd;
  logic        in_valid;
  logic [5:0]  in_op;
  logic [4:0]  in_rd, in_rt;
  logic [31:0] in_ot, in_addr, in_res;
  logic        flush, out_ready, clr_stats;

  logic        s1_irdy, s1_ov, s0_irdy, s0_ov, c4_irdy, c4_ov;
  logic [5:0]  s1_op, s0_op, c4_op;
  logic [4:0]  s1_rd, s1_rt, s0_rd, s0_rt, c4_rd, c4_rt;
  logic [31:0] s1_ot, s1_addr, s1_res, s0_ot, s0_addr, s0_res, c4_ot, c4_addr, c4_res;
  logic [15:0] s1_cnt, s0_cnt;
  logic [3:0]  c4_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.SKID(1), .CNTW(16)) u_s1 (
    .clk(clk), .rstd(rstd), .in_valid(in_valid), .in_ready(s1_irdy),
    .in_op(in_op), .in_rd(in_rd), .in_rt(in_rt), .in_ot(in_ot), .in_addr(in_addr), .in_res(in_res),
    .flush(flush), .out_valid(s1_ov), .out_ready(out_ready), .out_op(s1_op),
    .out_rd(s1_rd), .out_rt(s1_rt), .out_ot(s1_ot), .out_addr(s1_addr), .out_res(s1_res),
    .clr_stats(clr_stats), .stall_cnt(s1_cnt));

  pipe_stage_skid #(.SKID(0), .CNTW(16)) u_s0 (
    .clk(clk), .rstd(rstd), .in_valid(in_valid), .in_ready(s0_irdy),
    .in_op(in_op), .in_rd(in_rd), .in_rt(in_rt), .in_ot(in_ot), .in_addr(in_addr), .in_res(in_res),
    .flush(flush), .out_valid(s0_ov), .out_ready(out_ready), .out_op(s0_op),
    .out_rd(s0_rd), .out_rt(s0_rt), .out_ot(s0_ot), .out_addr(s0_addr), .out_res(s0_res),
    .clr_stats(clr_stats), .stall_cnt(s0_cnt));

  pipe_stage_skid #(.SKID(1), .CNTW(4)) u_c4 (
    .clk(clk), .rstd(rstd), .in_valid(in_valid), .in_ready(c4_irdy),
    .in_op(in_op), .in_rd(in_rd), .in_rt(in_rt), .in_ot(in_ot), .in_addr(in_addr), .in_res(in_res),
    .flush(flush), .out_valid(c4_ov), .out_ready(out_ready), .out_op(c4_op),
    .out_rd(c4_rd), .out_rt(c4_rt), .out_ot(c4_ot), .out_addr(c4_addr), .out_res(c4_res),
    .clr_stats(clr_stats), .stall_cnt(c4_cnt));

  typedef struct {
    bit         iv;
    logic [5:0] op;
    bit         ordy;
    bit         fl;
    bit         clr;
    bit         e_ov;
    logic [5:0] e_op;
    bit         e_irdy;
    int         e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Payload fields are derived from the opcode so field corruption is visible.
  task automatic drive(input bit iv, input logic [5:0] op, input bit ordy, input bit fl, input bit clr);
    in_valid  = iv;
    in_op     = op;
    in_rd     = op[4:0];
    in_rt     = ~op[4:0];
    in_ot     = 32'(op) * 32'd3;
    in_addr   = 32'(op) + 32'd100;
    in_res    = 32'(op) << 4;
    out_ready = ordy;
    flush     = fl;
    clr_stats = clr;
  endtask

  function automatic void add(bit iv, logic [5:0] op, bit ordy, bit fl, bit clr,
                              bit e_ov, logic [5:0] e_op, bit e_irdy, int e_stall);
    vec_t v;
    v.iv = iv; v.op = op; v.ordy = ordy; v.fl = fl; v.clr = clr;
    v.e_ov = e_ov; v.e_op = e_op; v.e_irdy = e_irdy; v.e_stall = e_stall;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    rstd = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_ov", 32'(s1_ov), 32'd0);
    check("rst_op", 32'(s1_op), 32'(NOP));
    check("rst_cnt", 32'(s1_cnt), 32'd0);
    rstd = 1'b1;
    #1;
    check("rst_irdy", 32'(s1_irdy), 32'd1);
    check("rst_s0_irdy", 32'(s0_irdy), 32'd1);
  endtask

  initial begin
    // Streaming: op k accepted on vector k-1, presented on vector k.
    add(1, 6'd1, 1, 0, 0, 0, NOP, 1, 0);
    for (int k = 1; k <= 7; k++) add(1, 6'(k + 1), 1, 0, 0, 1, 6'(k), 1, 0);
    add(0, 6'd0, 1, 0, 0, 1, 6'd8, 1, 0);
    add(0, 6'd0, 1, 0, 0, 0, NOP, 1, 0);
    // Skid capture under a 3-cycle stall, then drain without loss.
    add(1, 6'd3, 1, 0, 0, 0, NOP, 1, 0);
    add(1, 6'd4, 0, 0, 0, 1, 6'd3, 1, 0);
    add(1, 6'd5, 0, 0, 0, 1, 6'd3, 0, 1);
    add(1, 6'd5, 0, 0, 0, 1, 6'd3, 0, 2);
    add(1, 6'd5, 1, 0, 0, 1, 6'd3, 0, 3);
    add(1, 6'd5, 1, 0, 0, 1, 6'd4, 1, 3);
    add(0, 6'd0, 1, 0, 0, 1, 6'd5, 1, 3);
    add(0, 6'd0, 1, 0, 0, 0, NOP, 1, 3);
    // Flush while in SKID with an incoming entry, then flush with an in_fire.
    add(1, 6'd9,  0, 0, 0, 0, NOP, 1, 3);
    add(1, 6'd10, 0, 0, 0, 1, 6'd9, 1, 3);
    add(1, 6'd11, 0, 1, 0, 1, 6'd9, 0, 4);
    add(0, 6'd0,  0, 0, 0, 0, NOP, 1, 5);
    add(1, 6'd12, 1, 1, 0, 0, NOP, 1, 5);
    add(0, 6'd0,  1, 0, 0, 0, NOP, 1, 5);
    add(0, 6'd0,  1, 0, 1, 0, NOP, 1, 5);
    add(0, 6'd0,  1, 0, 0, 0, NOP, 1, 0);

    do_reset();
    check("rst_res", s1_res, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].op, vecs[i].ordy, vecs[i].fl, vecs[i].clr);
      #1;
      check($sformatf("v%0d_ov", i), 32'(s1_ov), 32'(vecs[i].e_ov));
      check($sformatf("v%0d_op", i), 32'(s1_op), 32'(vecs[i].e_op));
      check($sformatf("v%0d_irdy", i), 32'(s1_irdy), 32'(vecs[i].e_irdy));
      check($sformatf("v%0d_cnt", i), 32'(s1_cnt), 32'(vecs[i].e_stall));
      check($sformatf("v%0d_c4cnt", i), 32'(c4_cnt), 32'(vecs[i].e_stall));
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d_res", i), s1_res, 32'(vecs[i].e_op) << 4);
        check($sformatf("v%0d_rd", i), 32'(s1_rd), 32'(vecs[i].e_op[4:0]));
      end
    end

    // Non-skid stage: ready follows out_ready combinationally, nothing taken while stalled.
    do_reset();
    @(negedge clk); drive(1, 6'd3, 1, 0, 0); #1;
    check("s0_c0_irdy", 32'(s0_irdy), 32'd1);
    check("s0_c0_ov", 32'(s0_ov), 32'd0);
    @(negedge clk); drive(1, 6'd4, 0, 0, 0); #1;
    check("s0_c1_op", 32'(s0_op), 32'd3);
    check("s0_c1_irdy", 32'(s0_irdy), 32'd0);
    out_ready = 1'b1; #1;
    check("s0_c1_irdy_comb", 32'(s0_irdy), 32'd1);
    out_ready = 1'b0; #1;
    check("s0_c1_irdy_back", 32'(s0_irdy), 32'd0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk); #1;
      check($sformatf("s0_c%0d_op", c), 32'(s0_op), 32'd3);
      check($sformatf("s0_c%0d_irdy", c), 32'(s0_irdy), 32'd0);
      check($sformatf("s0_c%0d_cnt", c), 32'(s0_cnt), 32'(c - 1));
    end
    @(negedge clk); drive(1, 6'd4, 1, 0, 0); #1;
    check("s0_c4_op", 32'(s0_op), 32'd3);
    check("s0_c4_irdy", 32'(s0_irdy), 32'd1);
    check("s0_c4_cnt", 32'(s0_cnt), 32'd3);
    @(negedge clk); drive(0, 6'd0, 1, 0, 0); #1;
    check("s0_c5_op", 32'(s0_op), 32'd4);
    check("s0_c5_res", s0_res, 32'd64);
    @(negedge clk); #1;
    check("s0_c6_ov", 32'(s0_ov), 32'd0);
    check("s0_c6_op", 32'(s0_op), 32'(NOP));

    // Counter saturation, clear while saturated, then asynchronous reset mid-stall.
    do_reset();
    @(negedge clk); drive(1, 6'd7, 0, 0, 0);
    @(negedge clk); drive(0, 6'd0, 0, 0, 0);
    repeat (20) @(negedge clk);
    #1;
    check("sat_c4", 32'(c4_cnt), 32'd15);
    check("sat_s1", 32'(s1_cnt), 32'd20);
    check("sat_op", 32'(c4_op), 32'd7);
    clr_stats = 1'b1;
    @(negedge clk); clr_stats = 1'b0; #1;
    check("clr_c4", 32'(c4_cnt), 32'd0);
    check("clr_s1", 32'(s1_cnt), 32'd0);
    @(negedge clk); #1;
    check("post_clr_c4", 32'(c4_cnt), 32'd1);
    #2;
    rstd = 1'b0;
    #1;
    check("arst_ov", 32'(s1_ov), 32'd0);
    check("arst_op", 32'(s1_op), 32'(NOP));
    check("arst_cnt", 32'(s1_cnt), 32'd0);
    check("arst_c4_cnt", 32'(c4_cnt), 32'd0);
    check("arst_res", s1_res, 32'd0);
    @(negedge clk);
    rstd = 1'b1;
    #1;
    check("arst_irdy", 32'(s1_irdy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
